// File: rtl/dds_channel_scheduler.sv
// Round-robin NCO channel scheduler sharing one dds core, with credit-gated issue and an AXI-Stream output.
// Optional build macro DDS_SCHED_DITHER_EN adds LFSR dither to the issued phase word.
module dds_channel_scheduler #(
  parameter int PHASE_DW   = 16,
  parameter int OUT_DW     = 16,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  cfg_wr,
  input  logic                  cfg_sel,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_DW-1:0]   cfg_data,
  input  logic                  cfg_clr,
  output logic [PHASE_DW-1:0]   dds_phase_tdata,
  output logic                  dds_phase_tvalid,
  input  logic [2*OUT_DW-1:0]   dds_out_tdata,
  input  logic                  dds_out_tvalid,
  output logic [2*OUT_DW-1:0]   m_axis_tdata,
  output logic [CH_W-1:0]       m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  err_tag,
  output logic                  err_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam int OF_W  = CH_W + 2*OUT_DW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic [CRD_W-1:0]    r_credits;
  logic [CH_W-1:0]     r_last;
  logic [PHASE_DW-1:0] r_acc [NUM_CH];
  logic [PHASE_DW-1:0] r_inc [NUM_CH];
  logic [PHASE_DW-1:0] r_off [NUM_CH];
  logic [PHASE_DW-1:0] r_phase;
  logic                r_phase_vld;
  logic [CH_W-1:0]     r_tag_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_tag_wr;
  logic [PTR_W:0]      r_tag_rd;
  logic [OF_W-1:0]     r_out_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_out_wr;
  logic [PTR_W:0]      r_out_rd;
  logic                r_err_tag;
  logic                r_err_ovf;

  logic                w_go;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W-1:0]     w_idx;
  logic                w_issue;
  logic                w_hs;
  logic                w_tag_empty;
  logic                w_out_empty;
  logic                w_out_full;
  logic                w_ret_pop;
  logic                w_out_push;
  logic [PHASE_DW-1:0] w_word;

  assign w_go        = run && (ch_en != '0);
  assign w_issue     = (r_state == ST_RUN) && (r_credits < CRD_W'(FIFO_DEPTH)) && w_gnt_vld;
  assign w_hs        = m_axis_tvalid && m_axis_tready;
  assign w_tag_empty = (r_tag_wr == r_tag_rd);
  assign w_out_empty = (r_out_wr == r_out_rd);
  assign w_out_full  = (r_out_wr[PTR_W] != r_out_rd[PTR_W]) &&
                       (r_out_wr[PTR_W-1:0] == r_out_rd[PTR_W-1:0]);
  assign w_ret_pop   = dds_out_tvalid && !w_tag_empty;
  assign w_out_push  = w_ret_pop && !w_out_full;

  // Cyclic search for the first enabled channel strictly after the last grant.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_last) + i) % NUM_CH);
      if (!w_gnt_vld && ch_en[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

`ifdef DDS_SCHED_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_issue) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Dither only perturbs the issued word; the accumulator stays exact.
  assign w_word = r_acc[w_gnt] + r_off[w_gnt] + PHASE_DW'(r_lfsr[3:0]);
`else
  assign w_word = r_acc[w_gnt] + r_off[w_gnt];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_go) r_state <= ST_RUN;
        ST_RUN:   if (!w_go) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_go)                  r_state <= ST_RUN;
          else if (r_credits == '0)  r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credits <= '0;
      r_last    <= CH_W'(NUM_CH - 1);
    end else begin
      case ({w_issue, w_hs})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
      if (w_issue) r_last <= w_gnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_inc[i] <= '0;
        r_off[i] <= '0;
      end
    end else if (cfg_wr) begin
      if (cfg_sel) r_off[cfg_ch] <= cfg_data;
      else         r_inc[cfg_ch] <= cfg_data;
    end
  end

  // Clear takes priority over the accumulate of a coincident issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (cfg_clr) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (w_issue) begin
      r_acc[w_gnt] <= r_acc[w_gnt] + r_inc[w_gnt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= '0;
      r_phase_vld <= 1'b0;
    end else begin
      r_phase_vld <= w_issue;
      if (w_issue) r_phase <= w_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_tag_mem[i] <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_issue) begin
        r_tag_mem[r_tag_wr[PTR_W-1:0]] <= w_gnt;
        r_tag_wr <= r_tag_wr + 1'b1;
      end
      if (w_ret_pop) r_tag_rd <= r_tag_rd + 1'b1;
    end
  end

  // Output FIFO is first-word-fall-through; head entry drives the stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_out_mem[i] <= '0;
      r_out_wr <= '0;
      r_out_rd <= '0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wr[PTR_W-1:0]] <= {r_tag_mem[r_tag_rd[PTR_W-1:0]], dds_out_tdata};
        r_out_wr <= r_out_wr + 1'b1;
      end
      if (w_hs) r_out_rd <= r_out_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_tag <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (dds_out_tvalid && w_tag_empty) r_err_tag <= 1'b1;
      if (w_ret_pop && w_out_full)       r_err_ovf <= 1'b1;
    end
  end

  assign dds_phase_tdata              = r_phase;
  assign dds_phase_tvalid             = r_phase_vld;
  assign m_axis_tvalid                = !w_out_empty;
  assign {m_axis_tuser, m_axis_tdata} = r_out_mem[r_out_rd[PTR_W-1:0]];
  assign busy                         = (r_state != ST_IDLE);
  assign err_tag                      = r_err_tag;
  assign err_ovf                      = r_err_ovf;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Directed bench for dds_channel_scheduler with a 4-cycle echo dds model.
module tb_dds_channel_scheduler;

  localparam int PHASE_DW   = 16;
  localparam int OUT_DW     = 16;
  localparam int NUM_CH     = 4;
  localparam int CH_W       = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int LAT        = 4;

  typedef logic [CH_W+2*OUT_DW-1:0] samp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                run;
  logic [NUM_CH-1:0]   ch_en;
  logic                cfg_wr;
  logic                cfg_sel;
  logic [CH_W-1:0]     cfg_ch;
  logic [PHASE_DW-1:0] cfg_data;
  logic                cfg_clr;
  logic [PHASE_DW-1:0] dds_phase_tdata;
  logic                dds_phase_tvalid;
  logic [2*OUT_DW-1:0] dds_out_tdata;
  logic                dds_out_tvalid;
  logic [2*OUT_DW-1:0] m_axis_tdata;
  logic [CH_W-1:0]     m_axis_tuser;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                busy;
  logic                err_tag;
  logic                err_ovf;
  logic                inj_vld;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [PHASE_DW-1:0] ph_q[$];
  int                  ph_cyc[$];
  samp_t               out_q[$];

  dds_channel_scheduler #(
    .PHASE_DW(PHASE_DW), .OUT_DW(OUT_DW), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ch_en(ch_en),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data), .cfg_clr(cfg_clr),
    .dds_phase_tdata(dds_phase_tdata), .dds_phase_tvalid(dds_phase_tvalid),
    .dds_out_tdata(dds_out_tdata), .dds_out_tvalid(dds_out_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .err_tag(err_tag), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // dds model: fixed latency, echoes the phase as {phase, ~phase}
  logic [PHASE_DW-1:0] mdl_ph [LAT];
  logic                mdl_v  [LAT];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        mdl_ph[i] <= '0;
        mdl_v[i]  <= 1'b0;
      end
    end else begin
      mdl_ph[0] <= dds_phase_tdata;
      mdl_v[0]  <= dds_phase_tvalid;
      for (int i = 1; i < LAT; i++) begin
        mdl_ph[i] <= mdl_ph[i-1];
        mdl_v[i]  <= mdl_v[i-1];
      end
    end
  end

  assign dds_out_tvalid = mdl_v[LAT-1] | inj_vld;
  assign dds_out_tdata  = {mdl_ph[LAT-1], ~mdl_ph[LAT-1]};

  always @(negedge clk) begin
    if (reset_n) begin
      if (dds_phase_tvalid) begin
        ph_q.push_back(dds_phase_tdata);
        ph_cyc.push_back(cyc);
      end
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tuser, m_axis_tdata});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0; run = 1'b0; ch_en = '0; cfg_wr = 1'b0; cfg_sel = 1'b0;
    cfg_ch = '0; cfg_data = '0; cfg_clr = 1'b0; m_axis_tready = 1'b1; inj_vld = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    ph_q.delete(); ph_cyc.delete(); out_q.delete();
  endtask

  task automatic cfg_write(input logic sel, input logic [CH_W-1:0] ch, input logic [PHASE_DW-1:0] d);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_issues(input int n, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dds_phase_tvalid) seen++;
      if (seen >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; run = 1'b0; ch_en = '0; cfg_wr = 1'b0; cfg_sel = 1'b0;
    cfg_ch = '0; cfg_data = '0; cfg_clr = 1'b0; m_axis_tready = 1'b1; inj_vld = 1'b0;
    tick(2);
    @(negedge clk);
    total++; if (dds_phase_tvalid !== 1'b0) begin bad++; $display("FAIL rst_phase_vld got %b want 0", dds_phase_tvalid); end
    total++; if (dds_phase_tdata !== '0) begin bad++; $display("FAIL rst_phase_data got %h want 0", dds_phase_tdata); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
    total++; if (m_axis_tuser !== '0) begin bad++; $display("FAIL rst_tuser got %h want 0", m_axis_tuser); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if ({err_tag, err_ovf} !== 2'b00) begin bad++; $display("FAIL rst_err got %b want 00", {err_tag, err_ovf}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(3);
    @(negedge clk);
    total++;
    if ({dds_phase_tvalid, dds_phase_tdata, m_axis_tvalid, m_axis_tdata, m_axis_tuser, busy, err_tag, err_ovf} !== '0) begin
      bad++;
      $display("FAIL rst_release_idle got pv=%b pd=%h tv=%b td=%h tu=%h busy=%b want all 0",
               dds_phase_tvalid, dds_phase_tdata, m_axis_tvalid, m_axis_tdata, m_axis_tuser, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep;
    bit ok1, ok2;
    logic [PHASE_DW-1:0] e;
    apply_reset;
    cfg_write(1'b0, 2'd0, 16'h1000);
    cfg_write(1'b1, 2'd0, 16'h0100);
    ch_en = 4'b0001;
    run = 1'b1;
    wait_issues(20, ok1);
    run = 1'b0;
    wait_idle(ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL sweep_timeout got issue_ok=%b idle_ok=%b want 1 1", ok1, ok2); end
    total++; if (ph_q.size() < 17) begin bad++; $display("FAIL sweep_count got %0d want >=17", ph_q.size()); end
    total++; if (out_q.size() != ph_q.size()) begin bad++; $display("FAIL sweep_out_count got %0d want %0d", out_q.size(), ph_q.size()); end
    if (ph_q.size() >= 17 && out_q.size() >= 17) begin
      for (int k = 0; k < 17; k++) begin
        e = 16'h0100 + 16'(k) * 16'h1000;
`ifdef DDS_SCHED_DITHER_EN
        total++;
        if (16'(ph_q[k] - e) > 16'd15) begin bad++; $display("FAIL sweep_dither[%0d] got %h want %h+0..15", k, ph_q[k], e); end
`else
        total++;
        if (ph_q[k] !== e) begin bad++; $display("FAIL sweep_phase[%0d] got %h want %h", k, ph_q[k], e); end
        total++;
        if (out_q[k] !== {2'd0, e, ~e}) begin bad++; $display("FAIL sweep_out[%0d] got %h want %h", k, out_q[k], {2'd0, e, ~e}); end
`endif
        total++;
        if (ph_cyc[k] - ph_cyc[0] != k) begin bad++; $display("FAIL sweep_gap[%0d] got %0d want %0d", k, ph_cyc[k] - ph_cyc[0], k); end
      end
    end
  endtask

  task automatic test_round_robin;
    bit ok1, ok2;
    int exp_tag [6] = '{0, 1, 3, 0, 1, 3};
    logic [PHASE_DW-1:0] p;
    samp_t ev;
    apply_reset;
    cfg_write(1'b1, 2'd1, 16'h1000);
    cfg_write(1'b1, 2'd3, 16'h3000);
    ch_en = 4'b1011;
    run = 1'b1;
    wait_issues(6, ok1);
    ch_en = 4'b0000;
    tick(2);
    @(negedge clk);
    total++; if (dds_phase_tvalid !== 1'b0) begin bad++; $display("FAIL rr_stop_issue got %b want 0", dds_phase_tvalid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_drain_busy got %b want 1", busy); end
    @(posedge clk); #1;
    wait_idle(ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL rr_timeout got issue_ok=%b idle_ok=%b want 1 1", ok1, ok2); end
    total++; if (out_q.size() != ph_q.size() || out_q.size() < 6) begin bad++; $display("FAIL rr_count got out=%0d issued=%0d want equal >=6", out_q.size(), ph_q.size()); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rr_idle_tvalid got %b want 0", m_axis_tvalid); end
    if (out_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        p  = 16'(exp_tag[k]) << 12;
        ev = {CH_W'(exp_tag[k]), p, ~p};
        total++;
        if (out_q[k] !== ev) begin bad++; $display("FAIL rr_out[%0d] got %h want %h", k, out_q[k], ev); end
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [PHASE_DW-1:0] p;
    samp_t ev;
    apply_reset;
    cfg_write(1'b0, 2'd0, 16'h0010);
    ch_en = 4'b0001;
    m_axis_tready = 1'b0;
    run = 1'b1;
    tick(30);
    @(negedge clk);
    total++; if (ph_q.size() != FIFO_DEPTH) begin bad++; $display("FAIL bp_issue_count got %0d want %0d", ph_q.size(), FIFO_DEPTH); end
    total++; if (dds_phase_tvalid !== 1'b0) begin bad++; $display("FAIL bp_stall got %b want 0", dds_phase_tvalid); end
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid got %b want 1", m_axis_tvalid); end
    total++; if ({m_axis_tuser, m_axis_tdata} !== {2'd0, 16'h0000, 16'hFFFF}) begin bad++; $display("FAIL bp_head got %h want %h", {m_axis_tuser, m_axis_tdata}, {2'd0, 16'h0000, 16'hFFFF}); end
    @(posedge clk); #1;
    run = 1'b0;
    tick(5);
    @(negedge clk);
    total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 16'h0000, 16'hFFFF}) begin bad++; $display("FAIL bp_hold got %h want %h", {m_axis_tvalid, m_axis_tdata}, {1'b1, 16'h0000, 16'hFFFF}); end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got busy=%b want 0", busy); end
    total++; if (out_q.size() != FIFO_DEPTH) begin bad++; $display("FAIL bp_out_count got %0d want %0d", out_q.size(), FIFO_DEPTH); end
    total++; if ({err_tag, err_ovf} !== 2'b00) begin bad++; $display("FAIL bp_err got %b want 00", {err_tag, err_ovf}); end
    if (out_q.size() == FIFO_DEPTH) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        p  = 16'(k) * 16'h0010;
        ev = {2'd0, p, ~p};
        total++;
        if (out_q[k] !== ev) begin bad++; $display("FAIL bp_out[%0d] got %h want %h", k, out_q[k], ev); end
      end
    end
  endtask

  task automatic test_cfg_collision;
    bit ok1, ok2;
    logic [PHASE_DW-1:0] exp_ph [8] = '{16'h0020, 16'h0120, 16'h0220, 16'h0320,
                                        16'h0420, 16'h0020, 16'h0021, 16'h0022};
    apply_reset;
    cfg_write(1'b0, 2'd0, 16'h0100);
    cfg_write(1'b1, 2'd0, 16'h0020);
    ch_en = 4'b0001;
    run = 1'b1;
    wait_issues(3, ok1);
    cfg_clr = 1'b1; cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 16'h0001;
    tick(1);
    cfg_clr = 1'b0; cfg_wr = 1'b0;
    tick(4);
    run = 1'b0;
    wait_idle(ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL col_timeout got issue_ok=%b idle_ok=%b want 1 1", ok1, ok2); end
    total++; if (ph_q.size() < 8) begin bad++; $display("FAIL col_count got %0d want >=8", ph_q.size()); end
    if (ph_q.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
`ifdef DDS_SCHED_DITHER_EN
        total++;
        if (16'(ph_q[k] - exp_ph[k]) > 16'd15) begin bad++; $display("FAIL col_phase[%0d] got %h want %h+0..15", k, ph_q[k], exp_ph[k]); end
`else
        total++;
        if (ph_q[k] !== exp_ph[k]) begin bad++; $display("FAIL col_phase[%0d] got %h want %h", k, ph_q[k], exp_ph[k]); end
`endif
      end
    end
  endtask

  task automatic test_async_reset_err;
    apply_reset;
    ch_en = 4'b0001;
    run = 1'b1;
    tick(5);
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (dds_phase_tvalid !== 1'b0) begin bad++; $display("FAIL ar_phase_vld got %b want 0", dds_phase_tvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got %b want 0", busy); end
    total++; if (dds_phase_tdata !== '0) begin bad++; $display("FAIL ar_phase_data got %h want 0", dds_phase_tdata); end
    run = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(2);
    inj_vld = 1'b1;
    tick(1);
    inj_vld = 1'b0;
    @(negedge clk);
    total++; if (err_tag !== 1'b1) begin bad++; $display("FAIL err_tag_set got %b want 1", err_tag); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL err_ovf_clear got %b want 0", err_ovf); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL err_drop got %b want 0", m_axis_tvalid); end
    @(posedge clk); #1;
    tick(5);
    @(negedge clk);
    total++; if (err_tag !== 1'b1) begin bad++; $display("FAIL err_tag_sticky got %b want 1", err_tag); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_round_robin;
    test_backpressure;
    test_cfg_collision;
    test_async_reset_err;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
